// File: rtl/convergecast_pkg.sv
// convergecast_pkg -- shared types and elaboration helpers for the convergecast
// min-reduction tree.
//   resp_t      : one response record (found, key, absolute node index), sized
//                 to the widest supported build; unused upper bits stay zero.
//   index_width : bits needed to name any of `nodes` sources (at least 1).
//   level_count : number of records present after `level` reduction stages.
//   tree_levels : number of registered reduction stages (at least 1).
package convergecast_pkg;

  // Widest key and index any build may request.
  localparam int KEY_WIDTH_MAX   = 64;
  localparam int INDEX_WIDTH_MAX = 32;

  typedef struct packed {
    logic                       found;
    logic [KEY_WIDTH_MAX-1:0]   key;
    logic [INDEX_WIDTH_MAX-1:0] index;
  } resp_t;

  function automatic int index_width(input int nodes);
    return (nodes <= 1) ? 1 : $clog2(nodes);
  endfunction

  function automatic int level_count(input int nodes, input int fanin, input int level);
    int cnt;
    cnt = nodes;
    for (int l = 0; l < level; l++) cnt = (cnt + fanin - 1) / fanin;
    return cnt;
  endfunction

  function automatic int tree_levels(input int nodes, input int fanin);
    int cnt;
    int lv;
    cnt = nodes;
    lv  = 0;
    for (int l = 0; l < 64; l++) begin
      if (cnt > 1) begin
        cnt = (cnt + fanin - 1) / fanin;
        lv++;
      end
    end
    return (lv < 1) ? 1 : lv;
  endfunction

endpackage

// File: rtl/convergecast_node.sv
// convergecast_node -- one registered reduction node of the convergecast tree.
// Picks the responding child with the smallest key; on equal keys the
// leftmost child wins, which is the lowest absolute index because children
// are ordered by index.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   valid_in     : the children carry a sample this cycle
//   kids         : FANIN child records (bit 0 = leftmost)
//   valid_out    : registered valid
//   rec_out      : registered winning record, all-zero if none found or invalid
module convergecast_node
  import convergecast_pkg::*;
#(
  parameter int FANIN = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_in,
  input  resp_t [FANIN-1:0]  kids,
  output logic               valid_out,
  output resp_t              rec_out
);

  resp_t best;

  // NOTE: best gets its default before the loop so every path assigns it
  // (no latch); combinational blocks use blocking '=', registers use '<='.
  always_comb begin
    best = '0;
    for (int c = 0; c < FANIN; c++) begin
      // Strict '<' keeps the earlier (lower-index) child on a tie.
      if (kids[c].found && (!best.found || (kids[c].key < best.key))) begin
        best = kids[c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      rec_out   <= '0;
    end else begin
      valid_out <= valid_in;
      rec_out   <= valid_in ? best : '0;
    end
  end

endmodule

// File: rtl/convergecast_tree.sv
// convergecast_tree -- pipelined min-key reduction over NODES response sources.
// Each sample reduces to the lowest key among responding nodes (lowest index
// on ties) after LEVELS registered stages; a new sample is accepted every
// cycle with no backpressure.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   in_valid      : the response vector is a sample to reduce
//   in_key_valid  : per-node response flag
//   in_keys       : per-node response key
//   out_valid     : reduced result available this cycle
//   out_found     : at least one node responded
//   out_key       : minimum responding key (0 if none / not valid)
//   out_index     : lowest node index holding that key (0 if none / not valid)
// KEY_WIDTH must not exceed 64 and MAX_FANIN must be at least 2.
module convergecast_tree
  import convergecast_pkg::*;
#(
  parameter  int KEY_WIDTH   = 16,
  parameter  int MAX_FANIN   = 3,
  parameter  int NODES       = 100,
  localparam int INDEX_WIDTH = index_width(NODES),
  localparam int LEVELS      = tree_levels(NODES, MAX_FANIN)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [NODES-1:0]                in_key_valid,
  input  logic [NODES-1:0][KEY_WIDTH-1:0] in_keys,
  output logic                            out_valid,
  output logic                            out_found,
  output logic [KEY_WIDTH-1:0]            out_key,
  output logic [INDEX_WIDTH-1:0]          out_index
);

  // stage[0] holds the raw leaf records; stage[l] holds the registered
  // outputs of reduction level l. Leaves carry their absolute index, so nodes
  // only forward the winner's index and never re-base it.
  for (genvar l = 0; l <= LEVELS; l++) begin : stage
    localparam int CNT = level_count(NODES, MAX_FANIN, l);
    logic              valid;
    resp_t [CNT-1:0]   rec;

    if (l == 0) begin : leaves
      // in_valid is not applied here; level-1 nodes ignore the leaves
      // entirely when it is low.
      assign valid = in_valid;
      for (genvar i = 0; i < NODES; i++) begin : leaf
        assign rec[i] = '{found: in_key_valid[i],
                          key:   KEY_WIDTH_MAX'(in_keys[i]),
                          index: INDEX_WIDTH_MAX'(i)};
      end
    end else begin : nodes
      localparam int PREV = level_count(NODES, MAX_FANIN, l - 1);
      logic [CNT-1:0] node_valid;

      // Group g reduces previous-level records g*MAX_FANIN onward; the last
      // group takes whatever remains.
      for (genvar g = 0; g < CNT; g++) begin : node
        localparam int FAN = ((PREV - g * MAX_FANIN) < MAX_FANIN) ?
                             (PREV - g * MAX_FANIN) : MAX_FANIN;
        convergecast_node #(
          .FANIN (FAN)
        ) u_node (
          .clock     (clock),
          .reset     (reset),
          .valid_in  (stage[l-1].valid),
          .kids      (stage[l-1].rec[g*MAX_FANIN +: FAN]),
          .valid_out (node_valid[g]),
          .rec_out   (rec[g])
        );
      end

      // Every node of a level sees the same valid, so their copies agree.
      assign valid = |node_valid;
    end
  end

  resp_t root;
  assign root = stage[LEVELS].rec[0];

  assign out_valid = stage[LEVELS].valid;
  assign out_found = root.found;
  assign out_key   = root.key[KEY_WIDTH-1:0];
  assign out_index = root.index[INDEX_WIDTH-1:0];

  // Upper record bits beyond this build's widths are always zero.
  logic unused_root;
  assign unused_root = ^root;

endmodule

// File: tb/tb_convergecast_tree.sv
// tb_convergecast_tree -- randomized self-checking bench for convergecast_tree.
// Three builds run side by side on one clock: A (NODES=100, fan-in 3),
// B (NODES=1) and C (NODES=3, fan-in 2). A reference model computes each
// sample's result directly (minimum key, then first index holding it) and
// schedules it LEVELS cycles ahead; every cycle all outputs are compared.
module tb_convergecast_tree;

  localparam int W    = 16;
  localparam int NMAX = 100;
  localparam int MAXC = 512;

  typedef struct {
    bit          v;
    bit          f;
    int unsigned key;
    int unsigned idx;
  } res_t;

  int nn [3] = '{100, 1, 3};
  int ff [3] = '{3, 3, 2};
  int lat[3];

  logic clock = 1'b0;
  logic reset;
  logic in_valid;

  logic [99:0]        kv_a;
  logic [99:0][W-1:0] keys_a;
  logic               ov_a, of_a;
  logic [W-1:0]       ok_a;
  logic [6:0]         oi_a;

  logic [0:0]         kv_b;
  logic [0:0][W-1:0]  keys_b;
  logic               ov_b, of_b;
  logic [W-1:0]       ok_b;
  logic [0:0]         oi_b;

  logic [2:0]         kv_c;
  logic [2:0][W-1:0]  keys_c;
  logic               ov_c, of_c;
  logic [W-1:0]       ok_c;
  logic [1:0]         oi_c;

  // Stimulus staging and model state.
  bit         kv  [3][NMAX];
  logic [W-1:0] keys[3][NMAX];
  res_t       expq[3][MAXC];
  res_t       zero_res;
  int         cyc;
  int         n_tests;
  int         n_fail;

  convergecast_tree #(.KEY_WIDTH(W), .MAX_FANIN(3), .NODES(100)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_key_valid(kv_a), .in_keys(keys_a),
    .out_valid(ov_a), .out_found(of_a), .out_key(ok_a), .out_index(oi_a));

  convergecast_tree #(.KEY_WIDTH(W), .MAX_FANIN(3), .NODES(1)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_key_valid(kv_b), .in_keys(keys_b),
    .out_valid(ov_b), .out_found(of_b), .out_key(ok_b), .out_index(oi_b));

  convergecast_tree #(.KEY_WIDTH(W), .MAX_FANIN(2), .NODES(3)) dut_c (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_key_valid(kv_c), .in_keys(keys_c),
    .out_valid(ov_c), .out_found(of_c), .out_key(ok_c), .out_index(oi_c));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Smallest L with fanin**L >= nodes, at least 1.
  function automatic int tb_levels(input int nodes, input int fanin);
    int l;
    int span;
    l    = 1;
    span = fanin;
    while (span < nodes) begin
      span = span * fanin;
      l++;
    end
    return l;
  endfunction

  function automatic res_t reduce(input int d);
    res_t r;
    logic [W-1:0] best;
    r    = zero_res;
    r.v  = 1'b1;
    best = '1;
    for (int i = 0; i < nn[d]; i++) begin
      if (kv[d][i]) begin
        r.f = 1'b1;
        if (keys[d][i] < best) best = keys[d][i];
      end
    end
    if (r.f) begin
      r.key = best;
      for (int i = nn[d] - 1; i >= 0; i--) begin
        if (kv[d][i] && keys[d][i] == best) r.idx = i;
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    logic [31:0] gv, gf, gk, gi;
    res_t e;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin gv = 32'(ov_a); gf = 32'(of_a); gk = 32'(ok_a); gi = 32'(oi_a); end
        1: begin gv = 32'(ov_b); gf = 32'(of_b); gk = 32'(ok_b); gi = 32'(oi_b); end
        default: begin gv = 32'(ov_c); gf = 32'(of_c); gk = 32'(ok_c); gi = 32'(oi_c); end
      endcase
      e = expq[d][cyc];
      check($sformatf("dut%0d valid c%0d", d, cyc), gv, 32'(e.v));
      check($sformatf("dut%0d found c%0d", d, cyc), gf, 32'(e.f));
      check($sformatf("dut%0d key c%0d", d, cyc), gk, e.key);
      check($sformatf("dut%0d index c%0d", d, cyc), gi, e.idx);
    end
  endtask

  // One cycle: compare outputs, then present the staged inputs and update
  // the model's schedule of future outputs.
  task automatic step(input bit rst, input bit v);
    @(negedge clock);
    check_outputs();
    reset    = rst;
    in_valid = v;
    for (int i = 0; i < 100; i++) begin
      kv_a[i]   = kv[0][i];
      keys_a[i] = keys[0][i];
    end
    kv_b[0]   = kv[1][0];
    keys_b[0] = keys[1][0];
    for (int i = 0; i < 3; i++) begin
      kv_c[i]   = kv[2][i];
      keys_c[i] = keys[2][i];
    end
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        for (int j = cyc + 1; j < MAXC; j++) expq[d][j] = zero_res;
      end else if (v) begin
        expq[d][cyc + lat[d]] = reduce(d);
      end
    end
    cyc++;
  endtask

  // No responders; keys are left random so non-responding keys must be ignored.
  task automatic clear_all();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < NMAX; i++) begin
        kv[d][i]   = 1'b0;
        keys[d][i] = W'($urandom_range(0, 65535));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      clear_all();
      step(1'b0, 1'b0);
    end
  endtask

  initial begin
    zero_res = '{v: 1'b0, f: 1'b0, key: 0, idx: 0};
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int d = 0; d < 3; d++) begin
      lat[d] = tb_levels(nn[d], ff[d]);
      for (int j = 0; j < MAXC; j++) expq[d][j] = zero_res;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    kv_a = '0; keys_a = '0; kv_b = '0; keys_b = '0; kv_c = '0; keys_c = '0;
    clear_all();

    // Reset state.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Single responder: node 42, key 7.
    clear_all();
    kv[0][42] = 1'b1; keys[0][42] = 16'd7;
    step(1'b0, 1'b1);
    idle(6);

    // Tie on key 3 between nodes 10 and 90; node 50 has key 4.
    clear_all();
    kv[0][10] = 1'b1; keys[0][10] = 16'd3;
    kv[0][90] = 1'b1; keys[0][90] = 16'd3;
    kv[0][50] = 1'b1; keys[0][50] = 16'd4;
    kv[2][1]  = 1'b1; keys[2][1]  = 16'd5;
    kv[2][2]  = 1'b1; keys[2][2]  = 16'd5;
    step(1'b0, 1'b1);
    idle(6);

    // Valid sample with no responders.
    clear_all();
    step(1'b0, 1'b1);
    idle(6);

    // Responders presented without in_valid must be ignored.
    clear_all();
    kv[0][5] = 1'b1; kv[1][0] = 1'b1; kv[2][0] = 1'b1;
    step(1'b0, 1'b0);
    idle(6);

    // Eight back-to-back samples: node 99 with key n.
    for (int n = 0; n < 8; n++) begin
      clear_all();
      kv[0][99] = 1'b1; keys[0][99] = W'(n);
      kv[1][0]  = 1'b1; keys[1][0]  = W'(n);
      kv[2][2]  = 1'b1; keys[2][2]  = W'(n);
      step(1'b0, 1'b1);
    end
    idle(7);

    // All-ones key at the highest index of each build.
    clear_all();
    kv[0][99] = 1'b1; keys[0][99] = 16'hFFFF;
    kv[1][0]  = 1'b1; keys[1][0]  = 16'hFFFF;
    kv[2][2]  = 1'b1; keys[2][2]  = 16'hFFFF;
    step(1'b0, 1'b1);
    idle(6);

    // Reset two cycles after a sample: the sample must never emerge.
    clear_all();
    kv[0][3] = 1'b1; keys[0][3] = 16'd9;
    step(1'b0, 1'b1);
    idle(1);
    clear_all();
    kv[0][4] = 1'b1; keys[0][4] = 16'd1;
    step(1'b1, 1'b1);
    idle(7);

    // Randomized traffic: mixed densities, narrow key ranges for ties,
    // occasional reset.
    for (int t = 0; t < 160; t++) begin
      int dens;
      bit narrow;
      case ($urandom_range(0, 3))
        0: dens = 0;
        1: dens = 3;
        2: dens = 30;
        default: dens = 90;
      endcase
      narrow = ($urandom_range(0, 1) == 1);
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < NMAX; i++) begin
          kv[d][i]   = ($urandom_range(0, 99) < dens);
          keys[d][i] = narrow ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 65535));
        end
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
